// File: rtl/demux_capture.sv
// Routes one input word stream to two single-entry output channels (manual select or A/B alternation).
// Latency: one cycle from accept to out_x/valid_x. Backpressure: in_ready is low when the target channel is full and its consumer is stalled.
// Reset is asynchronous and active-high; buffered words and counters are discarded.
module demux_capture #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto_mode,
    output logic             next_sel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             valid_a,
    output logic             valid_b,
    input  logic             ready_a,
    input  logic             ready_b,
    output logic [3:0]       cnt_a,
    output logic [3:0]       cnt_b
);

    logic toggle;
    logic target;
    logic accept;
    logic load_a;
    logic load_b;
    logic drain_a;
    logic drain_b;

    always_comb begin
        target   = auto_mode ? toggle : in_sel;
        next_sel = target;
        // A slot can take a word if it is empty or is being drained this same cycle.
        in_ready = target ? (~valid_b | ready_b) : (~valid_a | ready_a);
        accept   = in_valid & in_ready;
        load_a   = accept & ~target;
        load_b   = accept & target;
        drain_a  = valid_a & ready_a;
        drain_b  = valid_b & ready_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a   <= '0;
            valid_a <= 1'b0;
            cnt_a   <= 4'd0;
        end else begin
            if (load_a) begin
                out_a   <= in_data;
                valid_a <= 1'b1;
                if (cnt_a != 4'd15) cnt_a <= cnt_a + 4'd1;
            end else if (drain_a) begin
                valid_a <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_b   <= '0;
            valid_b <= 1'b0;
            cnt_b   <= 4'd0;
        end else begin
            if (load_b) begin
                out_b   <= in_data;
                valid_b <= 1'b1;
                if (cnt_b != 4'd15) cnt_b <= cnt_b + 4'd1;
            end else if (drain_b) begin
                valid_b <= 1'b0;
            end
        end
    end

    // Cleared whenever auto mode is off so every auto sequence begins at channel A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             toggle <= 1'b0;
        else if (!auto_mode) toggle <= 1'b0;
        else if (accept)     toggle <= ~toggle;
    end

endmodule

// File: doc/demux_capture.md
DEMUX_CAPTURE -- requirements
Module: demux_capture

Interface
REQ-001 Parameter: WIDTH, default 3, data width of input and both output channels.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  WIDTH  multiplexed input word.
REQ-005 in_sel  input  1  channel select in manual mode: 0 = channel A, 1 = channel B.
REQ-006 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 auto_mode  input  1  1 = ignore in_sel and alternate A,B,A,B...
REQ-009 next_sel  output  1  channel that will receive the next accepted word.
REQ-010 out_a, out_b  output  WIDTH  registered channel data.
REQ-011 valid_a, valid_b  output  1  channel holds an undelivered word.
REQ-012 ready_a, ready_b  input  1  downstream consumer ready, per channel.
REQ-013 cnt_a, cnt_b  output  4  saturating count of words accepted per channel.

Function
REQ-014 The target channel SHALL be toggle when auto_mode=1, else in_sel; next_sel SHALL equal the target (combinational).
REQ-015 in_ready SHALL be (~valid_t | ready_t) for target channel t, combinational, independent of in_valid.
REQ-016 Accept = in_valid & in_ready; on accept, out_t SHALL load in_data and valid_t SHALL be 1 on the next edge (1-cycle latency).
REQ-017 Drain = valid_x & ready_x; on drain without simultaneous load, valid_x SHALL clear next edge and out_x SHALL hold its value.
REQ-018 Simultaneous drain and load on the same channel SHALL keep valid_t=1 and replace out_t with the new word (no bubble).
REQ-019 While valid_x=1 and ready_x=0, out_x and valid_x SHALL remain stable.
REQ-020 The non-target channel SHALL be unaffected by input activity; both channels SHALL drain independently in the same cycle.
REQ-021 in_valid=1 with in_ready=0 SHALL cause no state change (word not taken; source holds).
REQ-022 toggle SHALL invert on every accept while auto_mode=1, and SHALL be forced to 0 on any cycle with auto_mode=0, so auto sequences always start at A.
REQ-023 cnt_x SHALL increment by 1 on each accept into channel x and saturate at 15 (no wrap).
REQ-024 Changing auto_mode or in_sel while a channel is full SHALL only affect target selection; buffered data is preserved.

Reset
REQ-025 While rst=1, and immediately on its assertion: out_a=out_b=0, valid_a=valid_b=0, cnt_a=cnt_b=0, toggle=0, regardless of clk.
REQ-026 Reset mid-operation SHALL discard buffered words; first accept after release behaves as from power-up.
REQ-027 During reset in_ready SHALL evaluate to 1 (both channels empty); accepts take effect only after rst deasserts.

Verification
REQ-028 Manual: rst release, auto_mode=0, in_sel=1, in_data=3'b101, in_valid=1 one cycle, ready_b=0 -> next cycle out_b=101, valid_b=1, valid_a=0, cnt_b=1.
REQ-029 Backpressure: B full, ready_b=0, in_sel=1, in_data=3'b010 held -> in_ready=0, out_b stays 101; raise ready_b -> in_ready=1, next edge out_b=010, valid_b=1.
REQ-030 Auto: auto_mode=1, ready_a=ready_b=1, in_data 1,2,3,4 on consecutive cycles -> out_a gets 1 then 3, out_b gets 2 then 4, next_sel sequence 0,1,0,1.
REQ-031 Saturation: 20 accepts into A with ready_a=1 -> cnt_a=15, cnt_b=0.
REQ-032 Async reset: assert rst between edges with valid_a=1, cnt_a=5 -> valid_a=0, out_a=0, cnt_a=0 before next clk edge; next_sel=0 after release in auto_mode.
